// File: rtl/ads1292_sample_framer.sv
// ---------------------------------------------------------------------------
// ads1292_sample_framer
//
// Output stage of the ADS1292 filter chain. It takes one filtered 24-bit Ch2
// sample over a valid/ack handshake. It wraps the sample in a 6-byte frame:
//   byte0 HEADER, byte1 seq, byte2 s[23:16], byte3 s[15:8], byte4 s[7:0], byte5 CHK
// It streams the frame byte by byte to the UART TX interface.
// CHK makes bytes 1..5 sum to zero mod 256.
// While a frame is in flight, no new sample is acked, so the filter stalls.
// When DECIMATION > 1, only one accepted sample in DECIMATION is framed. The
// others are acked and then dropped.
//
// Ports
//   i_CLK                          clock
//   i_RSTN                         asynchronous active-low reset
//   i_ADS1292_FILTERED_DATA        24-bit sample, stable while VALID is high
//   i_ADS1292_FILTERED_DATA_VALID  sample valid, held until acked
//   o_ADS1292_FILTERED_DATA_ACK    one-cycle pulse: sample taken
//   o_TX_DATA                      frame byte to UART TX
//   o_TX_DATA_VALID                o_TX_DATA valid, held until acked
//   i_TX_DATA_ACK                  UART TX took the byte
//   o_BUSY                         high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module ads1292_sample_framer #(
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned DECIMATION = 1
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [23:0] i_ADS1292_FILTERED_DATA,
  input  logic        i_ADS1292_FILTERED_DATA_VALID,
  output logic        o_ADS1292_FILTERED_DATA_ACK,
  output logic [7:0]  o_TX_DATA,
  output logic        o_TX_DATA_VALID,
  input  logic        i_TX_DATA_ACK,
  output logic        o_BUSY
);

  localparam logic [7:0] DEC_LAST = 8'(DECIMATION - 1);
  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_LOAD,
    ST_SEND
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] sample_q, sample_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  decim_q, decim_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic        ack_q, ack_d;
  logic [7:0]  txd_q, txd_d;
  logic        txv_q, txv_d;

  // Frame bytes. Element 0 goes out first.
  logic [5:0][7:0] frame;
  logic [7:0]      sum;
  logic [2:0]      idx_nxt;

  assign frame   = {chk_q, sample_q[7:0], sample_q[15:8], sample_q[23:16], seq_q, HEADER};
  assign sum     = seq_q + sample_q[23:16] + sample_q[15:8] + sample_q[7:0];
  assign idx_nxt = idx_q + 3'd1;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    seq_d    = seq_q;
    decim_d  = decim_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    // The ack defaults low, so it can only ever be a single-cycle pulse.
    ack_d    = 1'b0;
    txd_d    = txd_q;
    txv_d    = txv_q;

    unique case (state_q)
      ST_IDLE: begin
        // Acks are issued only from here. A VALID level that is still high
        // cannot be acked twice, and nothing is acked mid-frame.
        if (i_ADS1292_FILTERED_DATA_VALID) begin
          sample_d = i_ADS1292_FILTERED_DATA;
          ack_d    = 1'b1;
          state_d  = (decim_q == 8'd0) ? ST_LOAD : ST_SKIP;
          decim_d  = (decim_q == DEC_LAST) ? 8'd0 : decim_q + 8'd1;
        end
      end

      ST_SKIP: begin
        // The sample is dropped by decimation. The sequence number is unchanged.
        state_d = ST_IDLE;
      end

      ST_LOAD: begin
        // Compute the checksum once here, so byte5 is a plain register read.
        chk_d   = 8'd0 - sum;
        txd_d   = HEADER;
        txv_d   = 1'b1;
        idx_d   = 3'd0;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (txv_q && i_TX_DATA_ACK) begin
          if (idx_q == LAST_IDX) begin
            txv_d   = 1'b0;
            seq_d   = seq_q + 8'd1;
            state_d = ST_IDLE;
          end else begin
            // Load the next byte on the same edge, so bytes go out back to
            // back with no gap cycle.
            idx_d = idx_nxt;
            txd_d = frame[idx_nxt];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      seq_q    <= '0;
      decim_q  <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      ack_q    <= 1'b0;
      txd_q    <= '0;
      txv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      seq_q    <= seq_d;
      decim_q  <= decim_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      ack_q    <= ack_d;
      txd_q    <= txd_d;
      txv_q    <= txv_d;
    end
  end

  assign o_ADS1292_FILTERED_DATA_ACK = ack_q;
  assign o_TX_DATA                   = txd_q;
  assign o_TX_DATA_VALID             = txv_q;
  assign o_BUSY                      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ads1292_sample_framer.sv
// Directed bench for ads1292_sample_framer.
// DUT A uses DECIMATION=1 and DUT B uses DECIMATION=4.
// The 'sel' signal routes the shared stimulus to one DUT and picks which
// DUT's outputs are observed.
module tb_ads1292_sample_framer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [23:0] din = '0;
  logic        dvalid = 1'b0;
  logic        txack = 1'b0;
  logic        sel = 1'b0;

  logic       ack_a, txv_a, busy_a, ack_b, txv_b, busy_b;
  logic [7:0] txd_a, txd_b;
  logic       ack, txv, busy;
  logic [7:0] txd;

  int tests = 0;
  int fails = 0;
  int ack_cnt_b = 0;

  always #5 clk = ~clk;

  ads1292_sample_framer #(.HEADER(8'hA5), .DECIMATION(1)) u_dut_a (
    .i_CLK                         (clk),
    .i_RSTN                        (rstn),
    .i_ADS1292_FILTERED_DATA       (din),
    .i_ADS1292_FILTERED_DATA_VALID (dvalid & ~sel),
    .o_ADS1292_FILTERED_DATA_ACK   (ack_a),
    .o_TX_DATA                     (txd_a),
    .o_TX_DATA_VALID               (txv_a),
    .i_TX_DATA_ACK                 (txack & ~sel),
    .o_BUSY                        (busy_a)
  );

  ads1292_sample_framer #(.HEADER(8'hA5), .DECIMATION(4)) u_dut_b (
    .i_CLK                         (clk),
    .i_RSTN                        (rstn),
    .i_ADS1292_FILTERED_DATA       (din),
    .i_ADS1292_FILTERED_DATA_VALID (dvalid & sel),
    .o_ADS1292_FILTERED_DATA_ACK   (ack_b),
    .o_TX_DATA                     (txd_b),
    .o_TX_DATA_VALID               (txv_b),
    .i_TX_DATA_ACK                 (txack & sel),
    .o_BUSY                        (busy_b)
  );

  assign ack  = sel ? ack_b  : ack_a;
  assign txv  = sel ? txv_b  : txv_a;
  assign busy = sel ? busy_b : busy_a;
  assign txd  = sel ? txd_b  : txd_a;

  always @(negedge clk) if (ack_b === 1'b1) ack_cnt_b++;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] exp_frame(input logic [7:0] s, input logic [23:0] d);
    logic [7:0] c;
    c = 8'd0 - (s + d[23:16] + d[15:8] + d[7:0]);
    return {8'hA5, s, d, c};
  endfunction

  // Present a sample and wait for its ack.
  // Returns at the negedge after the ack pulse, after checking that the
  // pulse lasted only one cycle.
  task automatic offer(input logic [23:0] d, output int waited);
    din    = d;
    dvalid = 1'b1;
    waited = 0;
    while (ack !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 30) chk("ack_timeout", {47'b0, ack}, 48'd1);
    dvalid = 1'b0;
    @(negedge clk);
    chk("ack_pulse", {47'b0, ack}, 48'd0);
  endtask

  // Collect six bytes. Byte 'gidx' is held for 'glen' cycles before its ack,
  // or every byte gets a random gap when rnd is set.
  task automatic collect(input int gidx, input int glen, input bit rnd, output logic [47:0] f);
    int k;
    int g;
    logic [7:0] cur;
    f = '0;
    for (int b = 0; b < 6; b++) begin
      k = 0;
      while (txv !== 1'b1 && k < 30) begin
        @(negedge clk);
        k++;
      end
      if (k >= 30) chk("tx_timeout", {47'b0, txv}, 48'd1);
      g = rnd ? int'($urandom_range(0, 3)) : ((b == gidx) ? glen : 0);
      cur = txd;
      for (int j = 0; j < g; j++) begin
        @(negedge clk);
        chk("hold", {45'b0, ack, txv, busy, txd}, {45'b0, 1'b0, 1'b1, 1'b1, cur});
      end
      f = {f[39:0], txd};
      txack = 1'b1;
      @(negedge clk);
      txack = 1'b0;
    end
    chk("frame_end", {46'b0, txv, busy}, 48'd0);
  endtask

  initial begin
    logic [47:0] f;
    logic [7:0]  seq;
    logic [7:0]  dseq;
    logic [23:0] d;
    logic [7:0]  s;
    int          w;
    int          nframes;

    // Reset state
    #12;
    chk("rst_a", {37'b0, ack_a, txv_a, busy_a, txd_a}, 48'd0);
    chk("rst_b", {37'b0, ack_b, txv_b, busy_b, txd_b}, 48'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 1: first frame after reset
    offer(24'h123456, w);
    collect(0, 0, 1'b0, f);
    chk("t1_frame", f, 48'hA5_00_12_34_56_64);

    // 2: second frame, then continue until the sequence number wraps
    offer(24'hFFFFFF, w);
    collect(0, 0, 1'b0, f);
    chk("t2_frame", f, 48'hA5_01_FF_FF_FF_02);
    seq = 8'd2;
    for (int i = 0; i < 255; i++) begin
      d = 24'(i * 32'h00010203 + 32'h00A0B0C0);
      offer(d, w);
      collect(0, 0, 1'b0, f);
      chk("wrap_loop", f, exp_frame(seq, d));
      seq = seq + 8'd1;
    end
    chk("t2_wrap_seq", {40'b0, f[39:32]}, 48'd0);

    // A TX ack while nothing is valid is ignored
    txack = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_txack", {46'b0, txv, busy}, 48'd0);
    txack = 1'b0;

    // 3: stall on byte3, while a new sample waits upstream
    offer(24'h123456, w);
    din    = 24'hABCDEF;
    dvalid = 1'b1;
    collect(3, 10, 1'b0, f);
    chk("t3_frame", f, exp_frame(seq, 24'h123456));
    chk("t3_byte3", {40'b0, f[23:16]}, 48'h34);
    seq = seq + 8'd1;
    offer(24'hABCDEF, w);
    chk("t3_ack_after_frame", 48'(w), 48'd1);
    collect(0, 0, 1'b0, f);
    chk("t3_next_frame", f, exp_frame(seq, 24'hABCDEF));
    seq = seq + 8'd1;

    // 4: DECIMATION=4 on DUT B
    sel     = 1'b1;
    dseq    = 8'd0;
    nframes = 0;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      offer(24'(i), w);
      chk("dec_txv", {47'b0, txv}, {47'b0, (i == 1 || i == 5)});
      if (txv === 1'b1) begin
        collect(0, 0, 1'b0, f);
        chk("dec_frame", f, exp_frame(dseq, 24'(i)));
        dseq = dseq + 8'd1;
        nframes++;
      end
    end
    @(negedge clk);
    chk("dec_frames", 48'(nframes), 48'd2);
    chk("dec_acks", 48'(ack_cnt_b), 48'd8);
    sel = 1'b0;
    @(negedge clk);

    // 5: reset during byte2
    offer(24'h777777, w);
    for (int b = 0; b < 2; b++) begin
      txack = 1'b1;
      @(negedge clk);
      txack = 1'b0;
    end
    chk("t5_byte2", {39'b0, txv, txd}, {39'b0, 1'b1, 8'h77});
    rstn = 1'b0;
    #1;
    chk("t5_rst_outs", {37'b0, ack_a, txv_a, busy_a, txd_a}, 48'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    offer(24'h000001, w);
    collect(0, 0, 1'b0, f);
    chk("t5_frame", f, 48'hA5_00_00_00_01_FF);
    seq = 8'd1;

    // 6: random TX ack gaps, scoreboarded
    for (int i = 0; i < 1000; i++) begin
      d = 24'($urandom);
      offer(d, w);
      collect(0, 0, 1'b1, f);
      chk("rnd_frame", f, exp_frame(seq, d));
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8] + f[7:0];
      chk("rnd_sum", {40'b0, s}, 48'd0);
      seq = seq + 8'd1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
